// File: rtl/axil_reg_slave.sv
// axil_reg_slave: AXI4-Lite slave with four 32-bit registers and independent read/write FSMs
module axil_reg_slave #(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 4
) (
   input  logic                            S_AXI_ACLK,
   input  logic                            S_AXI_ARESET,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
   input  logic [2:0]                      S_AXI_AWPROT,
   input  logic                            S_AXI_AWVALID,
   output logic                            S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
   input  logic                            S_AXI_WVALID,
   output logic                            S_AXI_WREADY,
   output logic [1:0]                      S_AXI_BRESP,
   output logic                            S_AXI_BVALID,
   input  logic                            S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
   input  logic [2:0]                      S_AXI_ARPROT,
   input  logic                            S_AXI_ARVALID,
   output logic                            S_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
   output logic [1:0]                      S_AXI_RRESP,
   output logic                            S_AXI_RVALID,
   input  logic                            S_AXI_RREADY,
   output logic [4*C_S_AXI_DATA_WIDTH-1:0] REGS_OUT
);
   localparam int DW = C_S_AXI_DATA_WIDTH;
   localparam int SW = DW / 8;
   typedef enum logic [1:0] {W_IDLE, W_HAVE_ADDR, W_HAVE_DATA, W_RESP} w_state_e;
   typedef enum logic {R_IDLE, R_DATA} r_state_e;
   w_state_e           r_wstate, w_wstate_nxt;
   r_state_e           r_rstate, w_rstate_nxt;
   logic               r_live;
   logic [1:0]         r_awidx;
   logic [DW-1:0]      r_wdata;
   logic [SW-1:0]      r_wstrb;
   logic [3:0][DW-1:0] r_regs;
   logic [DW-1:0]      r_rdata;
   logic               w_aw_hs, w_w_hs, w_ar_hs, w_commit;
   logic [1:0]         w_idx;
   logic [DW-1:0]      w_data, w_merged;
   logic [SW-1:0]      w_strb;
   logic               w_unused;
   // r_live keeps every READY low through reset and for the edge that releases it
   assign S_AXI_AWREADY = r_live && (r_wstate == W_IDLE || r_wstate == W_HAVE_DATA);
   assign S_AXI_WREADY  = r_live && (r_wstate == W_IDLE || r_wstate == W_HAVE_ADDR);
   assign S_AXI_BVALID  = r_wstate == W_RESP;
   assign S_AXI_BRESP   = 2'b00;
   assign S_AXI_ARREADY = r_live && r_rstate == R_IDLE;
   assign S_AXI_RVALID  = r_rstate == R_DATA;
   assign S_AXI_RRESP   = 2'b00;
   assign S_AXI_RDATA   = r_rdata;
   assign REGS_OUT      = r_regs;
   assign w_aw_hs       = S_AXI_AWVALID && S_AXI_AWREADY;
   assign w_w_hs        = S_AXI_WVALID && S_AXI_WREADY;
   assign w_ar_hs       = S_AXI_ARVALID && S_AXI_ARREADY;
   assign w_unused      = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};
   always_comb begin
      w_wstate_nxt = r_wstate;
      case (r_wstate)
         W_IDLE:      w_wstate_nxt = (w_aw_hs && w_w_hs) ? W_RESP :
                                     w_aw_hs ? W_HAVE_ADDR : w_w_hs ? W_HAVE_DATA : W_IDLE;
         W_HAVE_ADDR: w_wstate_nxt = w_w_hs ? W_RESP : W_HAVE_ADDR;
         W_HAVE_DATA: w_wstate_nxt = w_aw_hs ? W_RESP : W_HAVE_DATA;
         default:     w_wstate_nxt = S_AXI_BREADY ? W_IDLE : W_RESP;
      endcase
      w_rstate_nxt = (r_rstate == R_IDLE) ? (w_ar_hs ? R_DATA : R_IDLE)
                                          : (S_AXI_RREADY ? R_IDLE : R_DATA);
      w_commit = (w_wstate_nxt == W_RESP) && (r_wstate != W_RESP);
      w_idx    = (r_wstate == W_HAVE_ADDR) ? r_awidx : S_AXI_AWADDR[3:2];
      w_data   = (r_wstate == W_HAVE_DATA) ? r_wdata : S_AXI_WDATA;
      w_strb   = (r_wstate == W_HAVE_DATA) ? r_wstrb : S_AXI_WSTRB;
      w_merged = r_regs[w_idx];
      for (int i = 0; i < SW; i++)
         w_merged[8*i +: 8] = w_strb[i] ? w_data[8*i +: 8] : r_regs[w_idx][8*i +: 8];
   end
   always_ff @(posedge S_AXI_ACLK) begin
      if (S_AXI_ARESET) begin
         r_live   <= 1'b0;
         r_wstate <= W_IDLE;
         r_rstate <= R_IDLE;
         r_awidx  <= '0;
         r_wdata  <= '0;
         r_wstrb  <= '0;
         r_regs   <= '0;
         r_rdata  <= '0;
      end else begin
         r_live   <= 1'b1;
         r_wstate <= w_wstate_nxt;
         r_rstate <= w_rstate_nxt;
         if (r_wstate == W_IDLE && w_aw_hs)
            r_awidx <= S_AXI_AWADDR[3:2];
         if (r_wstate == W_IDLE && w_w_hs) begin
            r_wdata <= S_AXI_WDATA;
            r_wstrb <= S_AXI_WSTRB;
         end
         if (w_commit)
            r_regs[w_idx] <= w_merged;
         if (w_ar_hs)
            r_rdata <= r_regs[S_AXI_ARADDR[3:2]];
      end
   end
endmodule

// File: tb/tb_axil_reg_slave.sv
// tb_axil_reg_slave: directed self-checking bench for axil_reg_slave
module tb_axil_reg_slave;
   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [3:0]   awaddr = '0, araddr = '0;
   logic         awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
   logic [31:0]  wdata = '0;
   logic [3:0]   wstrb = '0;
   logic         awready, wready, bvalid, arready, rvalid;
   logic [1:0]   bresp, rresp;
   logic [31:0]  rdata, rd;
   logic [127:0] regs_out;
   int           n_checks = 0, n_errors = 0;

   axil_reg_slave dut (
      .S_AXI_ACLK(clk), .S_AXI_ARESET(rst),
      .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(3'b000), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
      .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
      .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
      .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(3'b000), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
      .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
      .REGS_OUT(regs_out)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
      bit aw_done = 0;
      bit w_done = 0;
      int n = 0;
      awaddr = a; awvalid = 1'b1; wdata = d; wstrb = s; wvalid = 1'b1; bready = 1'b1;
      while (!(aw_done && w_done) && n < 20) begin
         if (awvalid && awready) aw_done = 1;
         if (wvalid && wready) w_done = 1;
         tick();
         if (aw_done) awvalid = 1'b0;
         if (w_done) wvalid = 1'b0;
         n++;
      end
      chk("wr_handshake", {aw_done, w_done}, 2'b11);
      n = 0;
      while (!bvalid && n < 20) begin
         tick();
         n++;
      end
      chk("wr_b_latency", n, 0);
      chk("wr_bresp", bresp, 2'b00);
      tick();
      chk("wr_b_clear", bvalid, 1'b0);
   endtask

   task automatic axi_read(input logic [3:0] a, output logic [31:0] d);
      int n = 0;
      araddr = a; arvalid = 1'b1; rready = 1'b1;
      while (!arready && n < 20) begin
         tick();
         n++;
      end
      tick();
      arvalid = 1'b0;
      chk("rd_r_latency", rvalid, 1'b1);
      chk("rd_rresp", rresp, 2'b00);
      d = rdata;
      tick();
      chk("rd_r_clear", rvalid, 1'b0);
   endtask

   initial begin
      repeat (3) tick();
      chk("rst_ready", {awready, wready, arready}, 3'b000);
      chk("rst_valid", {bvalid, rvalid}, 2'b00);
      chk("rst_rdata", rdata, 32'h0);
      chk("rst_regs", regs_out, 128'h0);
      rst = 1'b0;
      chk("rel_ready_pre", {awready, wready, arready}, 3'b000);
      tick();
      chk("rel_ready_post", {awready, wready, arready}, 3'b111);

      // basic writes then readback of each register
      for (int i = 0; i < 4; i++) axi_write(4'(4 * i), 32'(i + 1), 4'hF);
      for (int i = 0; i < 4; i++) begin
         axi_read(4'(4 * i), rd);
         chk($sformatf("basic_rd%0d", i), rd, 32'(i + 1));
      end
      chk("basic_regs_out", regs_out, {32'h4, 32'h3, 32'h2, 32'h1});

      // byte strobes, and low address bits ignored
      axi_write(4'h4, 32'hAABBCCDD, 4'hF);
      axi_write(4'h4, 32'h11223344, 4'h5);
      axi_read(4'h4, rd);
      chk("strb_rd", rd, 32'hAA22CC44);
      axi_read(4'h6, rd);
      chk("lowbits_rd", rd, 32'hAA22CC44);

      // data three cycles ahead of address, response held by BREADY low
      bready = 1'b0;
      wdata = 32'hDEADBEEF; wstrb = 4'hF; wvalid = 1'b1;
      tick();
      wvalid = 1'b0;
      chk("wfirst_wready", wready, 1'b0);
      chk("wfirst_awready", awready, 1'b1);
      tick(); tick();
      chk("wfirst_no_b", bvalid, 1'b0);
      chk("wfirst_reg2_hold", regs_out[95:64], 32'h3);
      awaddr = 4'h8; awvalid = 1'b1;
      tick();
      awvalid = 1'b0;
      chk("wfirst_bvalid", bvalid, 1'b1);
      chk("wfirst_reg2", regs_out[95:64], 32'hDEADBEEF);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("bstall_bvalid", bvalid, 1'b1);
         chk("bstall_ready", {awready, wready}, 2'b00);
      end
      bready = 1'b1;
      tick();
      chk("bstall_release", {bvalid, awready, wready}, 3'b011);

      // read response held by RREADY low
      araddr = 4'h4; arvalid = 1'b1; rready = 1'b0;
      tick();
      arvalid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("rstall_rvalid", rvalid, 1'b1);
         chk("rstall_rdata", rdata, 32'hAA22CC44);
         chk("rstall_arready", arready, 1'b0);
      end
      rready = 1'b1;
      tick();
      chk("rstall_release", {rvalid, arready}, 2'b01);

      // read and write of reg3 on the same edge sees the old value
      awaddr = 4'hC; awvalid = 1'b1; wdata = 32'h9; wstrb = 4'hF; wvalid = 1'b1;
      araddr = 4'hC; arvalid = 1'b1; rready = 1'b0; bready = 1'b1;
      tick();
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
      chk("same_rdata", rdata, 32'h4);
      chk("same_valids", {bvalid, rvalid}, 2'b11);
      chk("same_reg3", regs_out[127:96], 32'h9);
      rready = 1'b1;
      tick();
      axi_read(4'hC, rd);
      chk("same_after_rd", rd, 32'h9);

      // reset after an address-only handshake discards the partial write
      awaddr = 4'h4; awvalid = 1'b1; bready = 1'b1;
      tick();
      awvalid = 1'b0;
      chk("mid_have_addr", {awready, wready}, 2'b01);
      rst = 1'b1;
      tick(); tick();
      chk("mid_rst_b", bvalid, 1'b0);
      chk("mid_rst_regs", regs_out, 128'h0);
      chk("mid_rst_ready", {awready, wready, arready}, 3'b000);
      rst = 1'b0;
      tick();
      chk("mid_rel_ready", {awready, wready, arready}, 3'b111);
      chk("mid_rel_b", bvalid, 1'b0);
      wdata = 32'h55; wstrb = 4'hF; wvalid = 1'b1;
      tick();
      wvalid = 1'b0;
      chk("mid_addr_dropped", {bvalid, awready, wready}, 3'b010);
      awaddr = 4'h0; awvalid = 1'b1;
      tick();
      awvalid = 1'b0;
      chk("mid_done_b", bvalid, 1'b1);
      tick();
      chk("mid_final_regs", regs_out, {96'h0, 32'h55});

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/axil_reg_slave.md
AXIL_REG_SLAVE -- requirements
Module: axil_reg_slave

Interface
REQ-001 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, AXI4-Lite data width; only 32 is supported.
REQ-002 SHALL have parameter C_S_AXI_ADDR_WIDTH, default 4, byte address width covering four 32-bit registers.
REQ-003 SHALL have one clock and one synchronous, active-high reset; all state changes on the rising edge of S_AXI_ACLK.
REQ-004 S_AXI_ACLK  in  1  clock.
REQ-005 S_AXI_ARESET  in  1  synchronous active-high reset.
REQ-006 S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address.
REQ-007 S_AXI_AWPROT  in  3  accepted and ignored.
REQ-008 S_AXI_AWVALID/S_AXI_AWREADY  in/out  1/1  write address handshake.
REQ-009 S_AXI_WDATA  in  32  write data.
REQ-010 S_AXI_WSTRB  in  4  byte enables; bit i enables WDATA[8i+7:8i].
REQ-011 S_AXI_WVALID/S_AXI_WREADY  in/out  1/1  write data handshake.
REQ-012 S_AXI_BRESP  out  2  write response, always 2'b00 (OKAY).
REQ-013 S_AXI_BVALID/S_AXI_BREADY  out/in  1/1  write response handshake.
REQ-014 S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read address.
REQ-015 S_AXI_ARPROT  in  3  accepted and ignored.
REQ-016 S_AXI_ARVALID/S_AXI_ARREADY  in/out  1/1  read address handshake.
REQ-017 S_AXI_RDATA  out  32  read data.
REQ-018 S_AXI_RRESP  out  2  read response, always 2'b00.
REQ-019 S_AXI_RVALID/S_AXI_RREADY  out/in  1/1  read data handshake.
REQ-020 REGS_OUT  out  128  live register contents; reg n on bits [32n+31:32n].

Function
REQ-021 SHALL decode register index from address bits [3:2]; bits [1:0] ignored; 0x0/0x4/0x8/0xC map to reg0..reg3.
REQ-022 Write FSM states: W_IDLE, W_HAVE_ADDR, W_HAVE_DATA, W_RESP.
REQ-023 W_IDLE: AWREADY=1, WREADY=1; AW-only handshake -> W_HAVE_ADDR (address latched); W-only handshake -> W_HAVE_DATA (data and strobe latched); both in the same cycle -> W_RESP.
REQ-024 W_HAVE_ADDR: AWREADY=0, WREADY=1; W handshake -> W_RESP.
REQ-025 W_HAVE_DATA: AWREADY=1, WREADY=0; AW handshake -> W_RESP.
REQ-026 Register write SHALL commit at the same edge as the completing handshake, applying WSTRB per byte; unstrobed bytes hold.
REQ-027 W_RESP: AWREADY=0, WREADY=0, BVALID=1; BVALID, BRESP held stable until BREADY=1, then -> W_IDLE.
REQ-028 Minimum write latency: BVALID high the cycle after the completing handshake; one outstanding write max.
REQ-029 Read FSM states: R_IDLE (ARREADY=1, RVALID=0) and R_DATA (ARREADY=0, RVALID=1).
REQ-030 AR handshake in R_IDLE SHALL latch RDATA from the addressed register and enter R_DATA next cycle.
REQ-031 RDATA, RRESP SHALL hold stable while RVALID=1 and RREADY=0; RREADY=1 -> R_IDLE; ARREADY high the following cycle.
REQ-032 Read and write FSMs SHALL operate independently and concurrently.
REQ-033 Read of the register written at the same edge SHALL return the pre-write value.
REQ-034 VALID inputs held during a READY-low cycle SHALL NOT be lost and SHALL NOT be double-accepted.

Reset
REQ-035 While S_AXI_ARESET=1 at an edge: reg0..reg3=0, REGS_OUT=0, AWREADY=WREADY=ARREADY=0, BVALID=RVALID=0, RDATA=0, BRESP=RRESP=0, both FSMs to idle.
REQ-036 READY outputs SHALL rise on the first edge with S_AXI_ARESET=0.
REQ-037 Reset mid-transaction SHALL discard latched partial address/data and any pending B/R response; no register update from a discarded write.

Verification
REQ-038 Writes of 0x1,0x2,0x3,0x4 to 0x0,0x4,0x8,0xC with WSTRB=0xF, then reads of the same addresses -> RDATA 0x1,0x2,0x3,0x4, all RESP=00.
REQ-039 reg1=0xAABBCCDD; write 0x11223344 to 0x4, WSTRB=0x5 -> read 0x4 returns 0xAA22CC44.
REQ-040 WVALID 3 cycles before AWVALID, to 0x8 with data 0xDEADBEEF -> WREADY drops after W handshake, single BVALID after AW handshake, reg2=0xDEADBEEF.
REQ-041 BREADY and RREADY held low 5 cycles -> BVALID/RVALID stay high, RDATA stable, AWREADY/WREADY/ARREADY stay low until released.
REQ-042 Same-cycle AR and AW/W to 0xC (old 0x4, new 0x9) -> RDATA=0x4; subsequent read returns 0x9.
REQ-043 Reset asserted one cycle after AW-only handshake -> no BVALID, all registers 0, READY outputs high the first cycle after release.
